// File: rtl/microsequencer_pkg.sv
// Shared control-unit definitions: next-state type encodings and the
// default microstore geometry used by the sequencer, microstore and control register.
package microsequencer_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 7;
    localparam int unsigned RESET_STATE_DEF = 0;
    localparam int unsigned FETCH_STATE_DEF = 1;

    typedef enum logic [2:0] {
        NS_DISPATCH  = 3'b000,
        NS_FETCH     = 3'b001,
        NS_JUMP      = 3'b010,
        NS_INCR      = 3'b011,
        NS_CJUMP     = 3'b100,
        NS_CDISPATCH = 3'b101,
        NS_CALL      = 3'b110,
        NS_CRETURN   = 3'b111
    } ns_type_e;

endpackage

// File: rtl/microsequencer_if.sv
// Control-register / decoder side of the microsequencer. There is no handshake:
// inputs are sampled every rising Clk edge and State/Return_State are registered outputs.
interface microsequencer_if
    import microsequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic                  Condition;
    logic                  Inv;
    logic [2:0]            N;
    logic [ADDR_WIDTH-1:0] CR_Address;
    logic [ADDR_WIDTH-1:0] Decoder_Address;
    logic [ADDR_WIDTH-1:0] State;
    logic [ADDR_WIDTH-1:0] Next_State;
    logic [ADDR_WIDTH-1:0] Return_State;

    modport master (
        output Condition, Inv, N, CR_Address, Decoder_Address,
        input  State, Next_State, Return_State
    );

    modport slave (
        input  Condition, Inv, N, CR_Address, Decoder_Address,
        output State, Next_State, Return_State
    );

endinterface

// File: rtl/microsequencer_next_state_select.sv
// Purely combinational next-microstate selection from the qualified condition,
// the next-state type and the candidate address sources.
module next_state_select
    import microsequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned FETCH_STATE = FETCH_STATE_DEF
) (
    input  logic                  cq_i,
    input  logic [2:0]            n_i,
    input  logic [ADDR_WIDTH-1:0] incr_i,
    input  logic [ADDR_WIDTH-1:0] state_i,
    input  logic [ADDR_WIDTH-1:0] cr_address_i,
    input  logic [ADDR_WIDTH-1:0] decoder_address_i,
    input  logic [ADDR_WIDTH-1:0] return_state_i,
    output logic [ADDR_WIDTH-1:0] next_state_o
);

    always_comb begin
        next_state_o = incr_i;
        case (ns_type_e'(n_i))
            NS_DISPATCH:  next_state_o = decoder_address_i;
            NS_FETCH:     next_state_o = ADDR_WIDTH'(FETCH_STATE);
            NS_JUMP:      next_state_o = cr_address_i;
            NS_INCR:      next_state_o = incr_i;
            NS_CJUMP:     next_state_o = cq_i ? cr_address_i : incr_i;
            NS_CDISPATCH: next_state_o = cq_i ? decoder_address_i : incr_i;
            NS_CALL:      next_state_o = cr_address_i;
            // A false condition holds in place: the memory-wait loop.
            NS_CRETURN:   next_state_o = cq_i ? return_state_i : state_i;
            default:      next_state_o = incr_i;
        endcase
    end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: current microstate register, single-level return
// register, incrementer and condition qualification.
module microsequencer
    import microsequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned RESET_STATE = RESET_STATE_DEF,
    parameter int unsigned FETCH_STATE = FETCH_STATE_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    microsequencer_if.slave  bus
);

    logic [ADDR_WIDTH-1:0] state_q,  state_d;
    logic [ADDR_WIDTH-1:0] return_q, return_d;
    logic [ADDR_WIDTH-1:0] incr;
    logic                  cq;

    assign cq   = bus.Condition ^ bus.Inv;
    assign incr = state_q + ADDR_WIDTH'(1);

    next_state_select #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .FETCH_STATE (FETCH_STATE)
    ) u_next_state_select (
        .cq_i              (cq),
        .n_i               (bus.N),
        .incr_i            (incr),
        .state_i           (state_q),
        .cr_address_i      (bus.CR_Address),
        .decoder_address_i (bus.Decoder_Address),
        .return_state_i    (return_q),
        .next_state_o      (state_d)
    );

    // Only a call writes the return register; nested calls simply overwrite it.
    always_comb begin
        return_d = return_q;
        if (ns_type_e'(bus.N) == NS_CALL) begin
            return_d = incr;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ADDR_WIDTH'(RESET_STATE);
            return_q <= ADDR_WIDTH'(RESET_STATE);
        end else begin
            state_q  <= state_d;
            return_q <= return_d;
        end
    end

    assign bus.State        = state_q;
    assign bus.Next_State   = state_d;
    assign bus.Return_State = return_q;

endmodule
